// File: rtl/hazard_scheduler.sv
// hazard_scheduler: pipeline forwarding, load-use/branch hazard control and a multi-cycle mul/div stall FSM.
module hazard_scheduler #(
  parameter int MUL_CYCLES = 3,
  parameter int DIV_CYCLES = 34
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] Rs1D,
  input  logic [4:0] Rs2D,
  input  logic [4:0] Rs1E,
  input  logic [4:0] Rs2E,
  input  logic [4:0] RdE,
  input  logic [4:0] RdM,
  input  logic [4:0] RdW,
  input  logic       RegWriteM,
  input  logic       RegWriteW,
  input  logic [1:0] ResultSrcE,
  input  logic       PCSrcE,
  input  logic       MdReqE,
  input  logic       MdDivE,
  output logic [1:0] ForwardAE,
  output logic [1:0] ForwardBE,
  output logic       StallF,
  output logic       StallD,
  output logic       StallE,
  output logic       FlushD,
  output logic       FlushE,
  output logic       BubbleM,
  output logic       MdStartE,
  output logic       MdDoneE,
  output logic       MdBusy
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  localparam logic [5:0] MUL_LD = 6'(MUL_CYCLES - 3);
  localparam logic [5:0] DIV_LD = 6'(DIV_CYCLES - 3);
  state_t state;
  logic [5:0] cnt;
  logic md_start, md_stall, lw_stall, m_a, m_b, w_a, w_b;
  always_comb begin
    m_a = RegWriteM && RdM != 5'd0 && RdM == Rs1E;
    m_b = RegWriteM && RdM != 5'd0 && RdM == Rs2E;
    w_a = RegWriteW && RdW != 5'd0 && RdW == Rs1E;
    w_b = RegWriteW && RdW != 5'd0 && RdW == Rs2E;
    lw_stall = ResultSrcE == 2'b01 && RdE != 5'd0 && (RdE == Rs1D || RdE == Rs2D);
    md_start = state == IDLE && MdReqE && !PCSrcE;
    // A request dropped mid-operation releases the pipeline in that same cycle.
    md_stall = !PCSrcE && (md_start || (state == BUSY && MdReqE));
    ForwardAE = !rst_n ? 2'b00 : m_a ? 2'b10 : w_a ? 2'b01 : 2'b00;
    ForwardBE = !rst_n ? 2'b00 : m_b ? 2'b10 : w_b ? 2'b01 : 2'b00;
    StallF   = rst_n && !PCSrcE && (md_stall || lw_stall);
    StallD   = rst_n && !PCSrcE && (md_stall || lw_stall);
    StallE   = rst_n && md_stall;
    BubbleM  = rst_n && md_stall;
    FlushD   = rst_n && PCSrcE;
    FlushE   = rst_n && (PCSrcE || (lw_stall && !md_stall));
    MdStartE = rst_n && md_start;
    MdDoneE  = rst_n && state == DONE;
    MdBusy   = rst_n && state != IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt <= 6'd0;
    end else begin
      case (state)
        IDLE: if (md_start) begin
          state <= BUSY;
          cnt <= MdDivE ? DIV_LD : MUL_LD;
        end
        BUSY: if (!MdReqE) begin
          state <= IDLE;
          cnt <= 6'd0;
        end else if (cnt == 6'd0) state <= DONE;
        else cnt <= cnt - 6'd1;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
